// File: rtl/gpr_mul_exec_if.sv
// rtl/gpr_mul_exec_if.sv - issue and register-file write-back bundle for the multiply execute stage
interface gpr_mul_exec_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [3:0]  dst_x;
  logic [3:0]  dst_y;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] C;
  logic [3:0]  WrtAdrX;
  logic        WrtEnbX;
  logic [31:0] X;
  logic [3:0]  WrtAdrY;
  logic        WrtEnbY;
  logic [31:0] Y;
  logic        busy;

  // Issuer / register-file side
  modport master (
    output in_valid, op, dst_x, dst_y, A, B, C,
    input  in_ready, WrtAdrX, WrtEnbX, X, WrtAdrY, WrtEnbY, Y, busy
  );

  // Execute stage side
  modport slave (
    input  in_valid, op, dst_x, dst_y, A, B, C,
    output in_ready, WrtAdrX, WrtEnbX, X, WrtAdrY, WrtEnbY, Y, busy
  );
endinterface

// File: rtl/gpr_mul_exec.sv
// rtl/gpr_mul_exec.sv - radix-2 shift-add multiply / multiply-accumulate execute stage
module gpr_mul_exec #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  gpr_mul_exec_if.slave bus
);

  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_MAC  = 2'b10;
  localparam logic [1:0] OP_MULW = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, WB} state_t;

  state_t      state, state_next;
  logic [4:0]  cnt, cnt_next;
  logic [63:0] acc, acc_next;
  logic [63:0] mcand, mcand_next;
  logic [31:0] mplier, mplier_next;
  logic [1:0]  op_q, op_next;
  logic [3:0]  dx_q, dx_next;
  logic [3:0]  dy_q, dy_next;
  logic        calc_done;

  // Next-state and datapath step: latch operands in IDLE, one multiplier bit per CALC cycle
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    acc_next    = acc;
    mcand_next  = mcand;
    mplier_next = mplier;
    op_next     = op_q;
    dx_next     = dx_q;
    dy_next     = dy_q;
    calc_done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_next  = {32'b0, bus.A};
          mplier_next = bus.B;
          op_next     = bus.op;
          dx_next     = bus.dst_x;
          dy_next     = bus.dst_y;
          acc_next    = (bus.op == OP_MAC) ? {32'b0, bus.C} : 64'b0;
          cnt_next    = 5'd0;
          state_next  = CALC;
        end
      end
      CALC: begin
        if (mplier[0]) begin
          acc_next = acc + mcand;
        end
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
        cnt_next    = cnt + 5'd1;
        // Early exit looks at the multiplier after this cycle's shift
        calc_done   = (cnt == 5'd31) || (EARLY_EXIT && (mplier[31:1] == 31'b0));
        if (calc_done) begin
          state_next = WB;
        end
      end
      WB: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial result
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      acc    <= 64'b0;
      mcand  <= 64'b0;
      mplier <= 32'b0;
      op_q   <= 2'b0;
      dx_q   <= 4'b0;
      dy_q   <= 4'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      acc    <= acc_next;
      mcand  <= mcand_next;
      mplier <= mplier_next;
      op_q   <= op_next;
      dx_q   <= dx_next;
      dy_q   <= dy_next;
    end
  end

  // Registered outputs, loaded from the next state so enables coincide exactly with WB
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.in_ready <= 1'b1;
      bus.busy     <= 1'b0;
      bus.WrtEnbX  <= 1'b0;
      bus.WrtEnbY  <= 1'b0;
      bus.WrtAdrX  <= 4'b0;
      bus.WrtAdrY  <= 4'b0;
      bus.X        <= 32'b0;
      bus.Y        <= 32'b0;
    end else begin
      bus.in_ready <= (state_next == IDLE);
      bus.busy     <= (state_next != IDLE);
      bus.WrtEnbX  <= (state_next == WB);
      // Same-address MULW writes only the low word so the result never depends on port priority
      bus.WrtEnbY  <= (state_next == WB) && (op_q == OP_MULW) && (dx_q != dy_q);
      if (state_next == WB) begin
        bus.WrtAdrX <= dx_q;
        bus.X       <= (op_q == OP_MULH) ? acc_next[63:32] : acc_next[31:0];
        if (op_q == OP_MULW) begin
          bus.WrtAdrY <= dy_q;
          bus.Y       <= acc_next[63:32];
        end
      end
    end
  end

endmodule

// File: tb/tb_gpr_mul_exec.sv
// tb/tb_gpr_mul_exec.sv - scoreboard bench for gpr_mul_exec with early exit on and off
module tb_gpr_mul_exec;

  localparam logic [1:0] MUL  = 2'b00;
  localparam logic [1:0] MULH = 2'b01;
  localparam logic [1:0] MAC  = 2'b10;
  localparam logic [1:0] MULW = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  dx;
    logic [3:0]  dy;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] x;
    logic [31:0] y;
    logic        ey;
    int          calc;
  } vec_t;

  typedef struct {
    int          wb_cyc;
    logic [3:0]  ax;
    logic [3:0]  ay;
    logic [31:0] x;
    logic [31:0] y;
    logic        ey;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  op = 2'b0;
  logic [3:0]  dst_x = 4'b0;
  logic [3:0]  dst_y = 4'b0;
  logic [31:0] a_in = 32'b0;
  logic [31:0] b_in = 32'b0;
  logic [31:0] c_in = 32'b0;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;
  exp_t exp_q[2][$];
  vec_t vt[7];

  gpr_mul_exec_if bus1();
  gpr_mul_exec_if bus0();

  assign bus1.in_valid = in_valid;
  assign bus1.op       = op;
  assign bus1.dst_x    = dst_x;
  assign bus1.dst_y    = dst_y;
  assign bus1.A        = a_in;
  assign bus1.B        = b_in;
  assign bus1.C        = c_in;
  assign bus0.in_valid = in_valid;
  assign bus0.op       = op;
  assign bus0.dst_x    = dst_x;
  assign bus0.dst_y    = dst_y;
  assign bus0.A        = a_in;
  assign bus0.B        = b_in;
  assign bus0.C        = c_in;

  gpr_mul_exec #(.EARLY_EXIT(1'b1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
  gpr_mul_exec #(.EARLY_EXIT(1'b0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int calc_cycles(input logic [31:0] b);
    int n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  // Per-cycle observer: every write-enable cycle must match the head of that DUT's queue
  task automatic mon(input int k, input logic ir, input logic bz, input logic ex, input logic [3:0] ax,
                     input logic [31:0] x, input logic ey, input logic [3:0] ay, input logic [31:0] y);
    exp_t e;
    check($sformatf("dut%0d_ready_vs_busy", k), {63'b0, ir}, {63'b0, ~bz});
    if (ex || ey) begin
      if (exp_q[k].size() == 0) begin
        check($sformatf("dut%0d_unexpected_write", k), 64'd1, 64'd0);
      end else begin
        e = exp_q[k].pop_front();
        check($sformatf("dut%0d_wb_cycle", k), 64'(cyc), 64'(e.wb_cyc));
        check($sformatf("dut%0d_ready_in_wb", k), {63'b0, ir}, 64'd0);
        check($sformatf("dut%0d_enx", k), {63'b0, ex}, 64'd1);
        check($sformatf("dut%0d_adrx", k), {60'b0, ax}, {60'b0, e.ax});
        check($sformatf("dut%0d_x", k), {32'b0, x}, {32'b0, e.x});
        check($sformatf("dut%0d_eny", k), {63'b0, ey}, {63'b0, e.ey});
        if (e.ey) begin
          check($sformatf("dut%0d_adry", k), {60'b0, ay}, {60'b0, e.ay});
          check($sformatf("dut%0d_y", k), {32'b0, y}, {32'b0, e.y});
        end
      end
    end
  endtask

  always @(negedge clock) begin
    if (mon_on) begin
      mon(1, bus1.in_ready, bus1.busy, bus1.WrtEnbX, bus1.WrtAdrX, bus1.X, bus1.WrtEnbY, bus1.WrtAdrY, bus1.Y);
      mon(0, bus0.in_ready, bus0.busy, bus0.WrtEnbX, bus0.WrtAdrX, bus0.X, bus0.WrtEnbY, bus0.WrtAdrY, bus0.Y);
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (!(bus1.in_ready && bus0.in_ready) && t < 200) begin
      @(negedge clock);
      t++;
    end
    check("idle_timeout", {63'b0, bus1.in_ready && bus0.in_ready}, 64'd1);
  endtask

  // Called at a negedge; waits for the early-exit DUT to be ready, drives one cycle, pushes expectations
  task automatic issue(input vec_t v, output int acc_cyc);
    exp_t e;
    int t = 0;
    acc_cyc = -1;
    while (!bus1.in_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!bus1.in_ready) begin
      check("issue_timeout", 64'd0, 64'd1);
      return;
    end
    op = v.op; dst_x = v.dx; dst_y = v.dy; a_in = v.a; b_in = v.b; c_in = v.c;
    in_valid = 1'b1;
    acc_cyc = cyc;
    e.ax = v.dx; e.ay = v.dy; e.x = v.x; e.y = v.y; e.ey = v.ey;
    e.wb_cyc = cyc + v.calc + 1;
    exp_q[1].push_back(e);
    if (bus0.in_ready) begin
      e.wb_cyc = cyc + 32 + 1;
      exp_q[0].push_back(e);
    end
    @(negedge clock);
    in_valid = 1'b0;
    check("ready_low_after_accept", {63'b0, bus1.in_ready}, 64'd0);
    check("busy_after_accept", {63'b0, bus1.busy}, 64'd1);
  endtask

  function automatic vec_t model(input logic [1:0] o, input logic [3:0] dx, input logic [3:0] dy,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    vec_t v;
    logic [63:0] p;
    p = ({32'b0, a} * {32'b0, b}) + ((o == MAC) ? {32'b0, c} : 64'b0);
    v.op = o; v.dx = dx; v.dy = dy; v.a = a; v.b = b; v.c = c;
    v.x = (o == MULH) ? p[63:32] : p[31:0];
    v.y = p[63:32];
    v.ey = (o == MULW) && (dx != dy);
    v.calc = calc_cycles(b);
    return v;
  endfunction

  initial begin
    vec_t v;
    int   c1, c2;

    //       op    dx     dy     a             b             c             x             y             ey    calc
    vt[0] = '{MUL,  4'd3,  4'd0,  32'd7,        32'd6,        32'd0,        32'h0000002A, 32'h0,        1'b0, 3};
    vt[1] = '{MULW, 4'd1,  4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'h00000001, 32'hFFFFFFFE, 1'b1, 32};
    vt[2] = '{MAC,  4'd5,  4'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h0,        1'b0, 32};
    vt[3] = '{MULH, 4'd6,  4'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFE, 32'h0,        1'b0, 32};
    vt[4] = '{MUL,  4'd7,  4'd0,  32'h55,       32'd0,        32'd0,        32'h00000000, 32'h0,        1'b0, 1};
    vt[5] = '{MAC,  4'd8,  4'd0,  32'h55,       32'd0,        32'h1234,     32'h00001234, 32'h0,        1'b0, 1};
    vt[6] = '{MULW, 4'd4,  4'd4,  32'h10000,    32'h10000,    32'd0,        32'h00000000, 32'h1,        1'b0, 17};

    repeat (2) @(negedge clock);
    check("rst_in_ready", {63'b0, bus1.in_ready}, 64'd1);
    check("rst_busy", {63'b0, bus1.busy}, 64'd0);
    check("rst_enx", {63'b0, bus1.WrtEnbX}, 64'd0);
    check("rst_eny", {63'b0, bus1.WrtEnbY}, 64'd0);
    check("rst_adrx", {60'b0, bus1.WrtAdrX}, 64'd0);
    check("rst_adry", {60'b0, bus1.WrtAdrY}, 64'd0);
    check("rst_x", {32'b0, bus1.X}, 64'd0);
    check("rst_y", {32'b0, bus1.Y}, 64'd0);
    reset = 1'b0;
    mon_on = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 7; i++) begin
      wait_idle();
      issue(vt[i], c1);
    end

    for (int i = 0; i < 6; i++) begin
      wait_idle();
      v = model(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), $urandom,
                $urandom >> $urandom_range(0, 31), $urandom);
      issue(v, c1);
    end

    // Back-to-back: second op is accepted the cycle after the first one's WB
    wait_idle();
    issue(model(MUL, 4'd9, 4'd0, 32'd11, 32'd5, 32'd0), c1);
    issue(model(MULW, 4'd10, 4'd11, 32'h89ABCDEF, 32'h00F0F00F, 32'd0), c2);
    check("back_to_back_accept", 64'(c2 - c1), 64'(3 + 2));

    // in_valid pulsed mid-CALC must be ignored by both instances
    wait_idle();
    issue(model(MUL, 4'd12, 4'd0, 32'h1234, 32'h80000000, 32'd0), c1);
    repeat (4) @(negedge clock);
    op = MULW; dst_x = 4'd13; dst_y = 4'd14; a_in = 32'd9; b_in = 32'd9;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;

    // Reset during CALC discards the operation; a fresh MUL then completes
    wait_idle();
    issue(model(MUL, 4'd15, 4'd0, 32'd3, 32'h80000000, 32'd0), c1);
    repeat (8) @(negedge clock);
    reset = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    @(negedge clock);
    reset = 1'b0;
    check("midrst_in_ready", {63'b0, bus1.in_ready}, 64'd1);
    check("midrst_busy", {63'b0, bus1.busy}, 64'd0);
    check("midrst_enx", {63'b0, bus1.WrtEnbX}, 64'd0);
    check("midrst_x", {32'b0, bus1.X}, 64'd0);
    check("midrst_dut0_busy", {63'b0, bus0.busy}, 64'd0);
    repeat (3) @(negedge clock);
    issue(model(MUL, 4'd2, 4'd0, 32'd3, 32'd5, 32'd0), c1);
    check("model_3x5", {32'b0, exp_q[1][0].x}, 64'h0000000F);

    wait_idle();
    repeat (2) @(negedge clock);
    check("dut1_queue_drained", 64'(exp_q[1].size()), 64'd0);
    check("dut0_queue_drained", 64'(exp_q[0].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
